// File: rtl/fp_sgnj_pkg.sv
// Shared types for the FP sign-injection arbiter: op encodings, slot states, word width.
package fp_sgnj_pkg;

   localparam int unsigned FLEN = 32;

   typedef enum logic [1:0] {
      OP_FSGNJ  = 2'b00,
      OP_FSGNJN = 2'b01,
      OP_FSGNJX = 2'b10,
      OP_ILL    = 2'b11
   } op_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

endpackage : fp_sgnj_pkg

// File: rtl/fsgnj_core.sv
// Combinational sign-injection datapath; magnitude always comes from rs1.
module fsgnj_core
   import fp_sgnj_pkg::*;
(
   input  logic [FLEN-1:0] rs1,
   input  logic [FLEN-1:0] rs2,
   input  logic [1:0]      op,
   output logic [FLEN-1:0] rd,
   output logic            err
);

   always_comb begin
      rd  = rs1;
      err = 1'b0;
      case (op_e'(op))
         OP_FSGNJ:  rd = {rs2[FLEN-1], rs1[FLEN-2:0]};
         OP_FSGNJN: rd = {~rs2[FLEN-1], rs1[FLEN-2:0]};
         OP_FSGNJX: rd = {rs1[FLEN-1] ^ rs2[FLEN-1], rs1[FLEN-2:0]};
         OP_ILL:    err = 1'b1;
         default:   err = 1'b1;
      endcase
   end

endmodule : fsgnj_core

// File: rtl/fsgnj_arbiter.sv
// Round-robin arbiter sharing one sign-injection datapath between NREQ requesters,
// with a single registered result slot.
module fsgnj_arbiter
   import fp_sgnj_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [FLEN*NREQ-1:0] req_rs1,
   input  logic [FLEN*NREQ-1:0] req_rs2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FLEN-1:0]      out_data,
   output logic [IDW-1:0]       out_id,
   output logic                 out_err
);

   // Rotate valids so the pointer sits at bit 0, take the lowest set bit, rotate back.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDW-1:0]  ptr);
      logic [2*NREQ-1:0] dbl;
      logic [NREQ-1:0]   rot;
      logic              found;
      int unsigned       pos;
      dbl   = {valid, valid};
      rot   = NREQ'(dbl >> ptr);
      found = 1'b0;
      pos   = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            pos   = i;
         end
      end
      pos = pos + 32'(ptr);
      if (pos >= NREQ) pos = pos - NREQ;
      return IDW'(pos);
   endfunction

   slot_state_e     state_q, state_d;
   logic [FLEN-1:0] data_q, data_d;
   logic [IDW-1:0]  id_q, id_d;
   logic            err_q, err_d;
   logic [IDW-1:0]  ptr_q, ptr_d;

   logic            slot_free;
   logic            grant;
   logic [IDW-1:0]  winner;
   logic [1:0]      sel_op;
   logic [FLEN-1:0] sel_rs1, sel_rs2;
   logic [FLEN-1:0] core_rd;
   logic            core_err;

   // Reset gates the grant so nothing is accepted while the slot is held clear.
   assign slot_free = (state_q == EMPTY) || out_ready;
   assign grant     = RST && EN && slot_free && (|req_valid);
   assign winner    = rr_pick(req_valid, ptr_q);
   assign req_ready = grant ? (NREQ'(1) << winner) : '0;

   always_comb begin
      sel_op  = '0;
      sel_rs1 = '0;
      sel_rs2 = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (IDW'(i) == winner) begin
            sel_op  = req_op[2*i +: 2];
            sel_rs1 = req_rs1[FLEN*i +: FLEN];
            sel_rs2 = req_rs2[FLEN*i +: FLEN];
         end
      end
   end

   fsgnj_core u_core (
      .rs1 (sel_rs1),
      .rs2 (sel_rs2),
      .op  (sel_op),
      .rd  (core_rd),
      .err (core_err)
   );

   // Slot FSM plus result/pointer next-state; a disabled block flushes the slot.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      err_d   = err_q;
      ptr_d   = ptr_q;
      if (!EN) begin
         state_d = EMPTY;
         data_d  = '0;
         id_d    = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            EMPTY:   if (grant) state_d = FULL;
            FULL:    if (out_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
         endcase
         if (grant) begin
            data_d = core_rd;
            id_d   = winner;
            err_d  = core_err;
            ptr_d  = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         err_q   <= err_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_id    = id_q;
   assign out_err   = err_q;

endmodule : fsgnj_arbiter
